// File: rtl/pll_reset_seq.sv
// pll_reset_seq: reset and lock sequencer around the system PLL.
//
// Pulses the PLL reset and waits for lock. Once lock has been stable, it releases the system
// reset and then the CPU reset. A lock timeout re-pulses the PLL reset. A later loss of lock
// re-arms the sequence without resetting the PLL.
// Runs on the free-running board reference clock, never on a PLL output.
//
// Parameters:
//   SYNC_STAGES     synchroniser depth for pll_locked (>= 2)
//   PLL_RST_CYCLES  cycles pll_rst is held high per pulse (>= 1)
//   LOCK_TIMEOUT    cycles allowed waiting for lock before a PLL reset retry
//   STABLE_CYCLES   consecutive locked cycles before sys_rst_n release (>= 1)
//   CPU_DELAY       cycles between sys_rst_n and cpu_rst_n release (>= 1)
//   CNT_W           shared counter width, must hold every cycle parameter
//
// Ports:
//   clk             free-running reference clock
//   rst_n           asynchronous active-low reset
//   pll_locked      PLL lock indicator, asynchronous to clk
//   soft_reset_req  one-cycle request to re-run the system/CPU reset (PLL untouched)
//   pll_rst         active-high PLL reset
//   sys_rst_n       active-low system reset, released first
//   cpu_rst_n       active-low CPU reset, released last
//   ready           high only while fully running
//   retry_cnt       lock-timeout retries since rst_n, saturating at 15

module pll_reset_seq #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1000000,
    parameter int unsigned STABLE_CYCLES  = 65536,
    parameter int unsigned CPU_DELAY      = 256,
    parameter int unsigned CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       cpu_rst_n,
    output logic       ready,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StStable,
        StSysUp,
        StRun
    } state_e;

    localparam logic [CNT_W-1:0] PllRstLast  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CpuLast     = CNT_W'(CPU_DELAY - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             retry_q, retry_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   pll_rst_q, sys_rst_n_q, cpu_rst_n_q, ready_q;

    // Lock synchroniser; only its last stage is used below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;

        unique case (state_q)
            StPllRst: begin
                if (cnt_q == PllRstLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            end
            StWaitLock: begin
                // Lock beats timeout when both happen together.
                if (locked_s) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StPllRst;
                    cnt_d   = '0;
                    if (retry_q != 4'hF) begin
                        retry_d = retry_q + 4'd1;
                    end
                end
            end
            StStable: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (soft_reset_req) begin
                    cnt_d = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = StSysUp;
                    cnt_d   = '0;
                end
            end
            StSysUp: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (soft_reset_req) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == CpuLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                // Counter is idle here and held at zero so it cannot wrap.
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = StWaitLock;
                end else if (soft_reset_req) begin
                    state_d = StStable;
                end
            end
            default: begin
                state_d = StPllRst;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StPllRst;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // Outputs are decoded from the next state so they switch with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            pll_rst_q   <= (state_d == StPllRst);
            sys_rst_n_q <= (state_d == StSysUp) || (state_d == StRun);
            cpu_rst_n_q <= (state_d == StRun);
            ready_q     <= (state_d == StRun);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign ready     = ready_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: scoreboard bench for pll_reset_seq.
//
// Stimulus pushes each expected output change (cycle number and output vector) into a queue.
// A monitor samples the outputs on every falling edge. Whenever the output vector changes, it
// pops the next expectation and compares both the value and the cycle.
// Output vector layout: {pll_rst, sys_rst_n, cpu_rst_n, ready, retry_cnt[3:0]}.

module tb_pll_reset_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b1;
    logic       soft_reset_req = 1'b0;
    logic       pll_rst, sys_rst_n, cpu_rst_n, ready;
    logic [3:0] retry_cnt;

    pll_reset_seq #(
        .SYNC_STAGES   (2),
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (100),
        .STABLE_CYCLES (32),
        .CPU_DELAY     (8),
        .CNT_W         (24)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .soft_reset_req(soft_reset_req),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .cpu_rst_n     (cpu_rst_n),
        .ready         (ready),
        .retry_cnt     (retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] prev_v = 8'b1000_0000;
    logic [7:0] cur_v;
    ev_t        ev;

    // Counts rising edges; sampled after the edge, so it names the edge the outputs follow.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cur_v = {pll_rst, sys_rst_n, cpu_rst_n, ready, retry_cnt};
        n_checks++;
        if (cpu_rst_n && !sys_rst_n) begin
            n_errors++;
            $display("FAIL order_inv: cpu_rst_n=1 with sys_rst_n=0 at cyc %0d", cyc);
        end
        n_checks++;
        if (pll_rst && (sys_rst_n || cpu_rst_n)) begin
            n_errors++;
            $display("FAIL pll_rst_inv: pll_rst=1 with sys/cpu=%b%b at cyc %0d",
                     sys_rst_n, cpu_rst_n, cyc);
        end
        if (cur_v !== prev_v) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_change: got %b at cyc %0d, required no change from %b",
                         cur_v, cyc, prev_v);
            end else begin
                ev = exp_q.pop_front();
                if (ev.val !== cur_v || ev.cyc != cyc) begin
                    n_errors++;
                    $display("FAIL sb_event: got %b at cyc %0d, required %b at cyc %0d",
                             cur_v, cyc, ev.val, ev.cyc);
                end
            end
            prev_v = cur_v;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic expect_ev(input int at, input logic [3:0] rst_bits, input logic [3:0] retry);
        ev_t e;
        e.cyc = at;
        e.val = {rst_bits, retry};
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    // Full bring-up from a rst_n release at cycle r with lock already present.
    task automatic expect_bringup(input int r, input logic [3:0] retry);
        expect_ev(r + 4,  4'b0000, retry);
        expect_ev(r + 37, 4'b0100, retry);
        expect_ev(r + 45, 4'b0111, retry);
    endtask

    int base;
    int r;
    int rk;

    initial begin
        #1 rst_n = 1'b0;

        // 1: power-up with lock tied high.
        repeat (3) step();
        rst_n = 1'b1;
        r = cyc;
        expect_bringup(r, 4'd0);
        wait_until(r + 50);
        check("t1_retry_zero", {4'b0, retry_cnt}, 8'd0);
        check("t1_run_outputs", {4'b0, pll_rst, sys_rst_n, cpu_rst_n, ready}, 8'b0000_0111);

        // 3: one-cycle lock loss in RUN, then full re-sequence without a PLL pulse.
        base = cyc;
        pll_locked = 1'b0;
        expect_ev(base + 3,  4'b0000, 4'd0);
        expect_ev(base + 36, 4'b0100, 4'd0);
        expect_ev(base + 44, 4'b0111, 4'd0);
        wait_until(base + 1);
        pll_locked = 1'b1;
        wait_until(base + 50);

        // 4: lock glitch at STABLE count 20 restarts the 32-cycle window.
        base = cyc;
        pll_locked = 1'b0;
        expect_ev(base + 3,  4'b0000, 4'd0);
        expect_ev(base + 58, 4'b0100, 4'd0);
        expect_ev(base + 66, 4'b0111, 4'd0);
        wait_until(base + 1);
        pll_locked = 1'b1;
        wait_until(base + 22);
        pll_locked = 1'b0;
        wait_until(base + 23);
        pll_locked = 1'b1;
        wait_until(base + 70);

        // 5a: soft reset in RUN.
        base = cyc;
        soft_reset_req = 1'b1;
        expect_ev(base + 1,  4'b0000, 4'd0);
        expect_ev(base + 33, 4'b0100, 4'd0);
        expect_ev(base + 41, 4'b0111, 4'd0);
        step();
        soft_reset_req = 1'b0;
        wait_until(base + 45);

        // 2 + 5b: lock lost for good; timeout retries every 104 cycles, retry_cnt saturates.
        // A soft request inside WAIT_LOCK must not disturb the timeout.
        base = cyc;
        pll_locked = 1'b0;
        expect_ev(base + 3, 4'b0000, 4'd0);
        for (int k = 0; k <= 16; k++) begin
            rk = (k + 1 > 15) ? 15 : k + 1;
            expect_ev(base + 103 + 104 * k, 4'b1000, 4'(rk));
            expect_ev(base + 107 + 104 * k, 4'b0000, 4'(rk));
        end
        wait_until(base + 50);
        soft_reset_req = 1'b1;
        step();
        soft_reset_req = 1'b0;
        wait_until(base + 1780);

        // 6: reach SYS_UP, then assert rst_n asynchronously mid-cycle.
        base = cyc;
        pll_locked = 1'b1;
        expect_ev(base + 35, 4'b0100, 4'd15);
        expect_ev(base + 40, 4'b1000, 4'd0);
        wait_until(base + 40);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_pll_rst", {7'b0, pll_rst}, 8'd1);
        check("t6_async_sys_rst_n", {7'b0, sys_rst_n}, 8'd0);
        check("t6_async_cpu_rst_n", {7'b0, cpu_rst_n}, 8'd0);
        check("t6_async_ready", {7'b0, ready}, 8'd0);
        check("t6_async_retry", {4'b0, retry_cnt}, 8'd0);
        step();
        step();
        rst_n = 1'b1;
        r = cyc;
        expect_bringup(r, 4'd0);
        wait_until(r + 50);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d expected events never seen, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
